// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type and counter width helper for the divider
package divider_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    FINAL = 2'd3
  } state_e;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/divider_if.sv
// divider_if: req/ack arithmetic request bus
//   req      start request              data_req {dividend[2N-1:0], divisor[N-1:0]}
//   ack      one-cycle result strobe    data_ack {remainder[N-1:0], quotient[N-1:0]}
//   err      divide-by-zero or quotient overflow, qualifies ack
interface divider_if #(parameter int DATA_WIDTH = 8);
  logic                    req;
  logic [3*DATA_WIDTH-1:0] data_req;
  logic                    ack;
  logic [2*DATA_WIDTH-1:0] data_ack;
  logic                    err;
  modport master(output req, data_req, input ack, data_ack, err);
  modport slave(input req, data_req, output ack, data_ack, err);
endinterface

// File: rtl/divider_step.sv
// divider_step: one restoring shift-and-subtract iteration
//   r_i      partial remainder (N+1 bits, always < d_i)
//   q_msb_i  next dividend bit shifted in
//   d_i      divisor
//   r_o      next partial remainder
//   q_o      quotient bit produced by this step
module divider_step #(parameter int N = 8) (
  input  logic [N:0]   r_i,
  input  logic         q_msb_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   r_o,
  output logic         q_o
);
  logic [N:0] t;
  always_comb begin
    t   = (r_i << 1) | (N+1)'(q_msb_i);
    q_o = t >= {1'b0, d_i};
    r_o = q_o ? t - {1'b0, d_i} : t;
  end
endmodule

// File: rtl/divider.sv
// divider: sequential restoring divider, 2N-bit dividend by N-bit divisor
//   clk  rising-edge clock
//   rst  synchronous active-high reset, aborts any operation
//   bus  slave side of divider_if (req/data_req in, ack/data_ack/err out)
module divider
  import divider_pkg::*;
#(parameter int DATA_WIDTH = 8) (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);
  localparam int N = DATA_WIDTH;
  localparam int CNT_W = cnt_w(N);
  state_e           state_q, state_d;
  logic [N:0]       r_q, r_d, step_r;
  logic [N-1:0]     q_q, q_d, d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, step_qb;
  divider_step #(.N(N)) u_step (
    .r_i    (r_q),
    .q_msb_i(q_q[N-1]),
    .d_i    (d_q),
    .r_o    (step_r),
    .q_o    (step_qb)
  );
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (bus.req) begin
        r_d     = {1'b0, bus.data_req[3*N-1:2*N]};
        q_d     = bus.data_req[2*N-1:N];
        d_d     = bus.data_req[N-1:0];
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = CHECK;
      end
      // a high half >= divisor means the quotient cannot fit in N bits
      CHECK: if (d_q == '0 || r_q[N-1:0] >= d_q) begin
        err_d   = 1'b1;
        q_d     = '1;
        r_d     = '0;
        state_d = FINAL;
      end else begin
        err_d   = 1'b0;
        state_d = ITER;
      end
      ITER: begin
        r_d     = step_r;
        q_d     = {q_q[N-2:0], step_qb};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(N-1) ? FINAL : ITER;
      end
      FINAL: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign bus.ack      = state_q == FINAL;
  assign bus.err      = err_q;
  assign bus.data_ack = {r_q[N-1:0], q_q};
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed table, corner sequences and random sweep for divider
module tb_divider;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  divider_if #(.DATA_WIDTH(8)) bus();
  divider #(.DATA_WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    int          lat;
    logic [15:0] dat;
    logic        e;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] x);
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, g, x);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [15:0] dd, input logic [7:0] dv,
                     output int lat, output logic [15:0] dat, output logic e);
    lat = -1;
    dat = '0;
    e = 1'b0;
    bus.req = 1'b1;
    bus.data_req = {dd, dv};
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      step();
      bus.req = 1'b0;
      if (bus.ack) begin
        lat = c;
        dat = bus.data_ack;
        e = bus.err;
      end
    end
    step();
    chk("ack_single_pulse", {31'd0, bus.ack}, 32'd0);
    chk("data_hold", {16'd0, bus.data_ack}, {16'd0, dat});
    chk("err_hold", {31'd0, bus.err}, {31'd0, e});
  endtask
  initial begin
    int lat, acks, a1, a2;
    logic [15:0] dat, d1, d2;
    logic e;
    tv[0] = '{16'h1234, 8'h56, 10, 16'h1036, 1'b0};
    tv[1] = '{16'h55AB, 8'h56, 10, 16'h01FF, 1'b0};
    tv[2] = '{16'h1234, 8'h00, 2, 16'h00FF, 1'b1};
    tv[3] = '{16'h5600, 8'h56, 2, 16'h00FF, 1'b1};
    tv[4] = '{16'h00FF, 8'h01, 10, 16'h00FF, 1'b0};
    tv[5] = '{16'h0064, 8'h07, 10, 16'h020E, 1'b0};
    rst = 1'b1;
    bus.req = 1'b0;
    bus.data_req = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_data", {16'd0, bus.data_ack}, 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      run(tv[i].dd, tv[i].dv, lat, dat, e);
      chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("vec%0d_data", i), {16'd0, dat}, {16'd0, tv[i].dat});
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tv[i].e});
    end
    // reset pulse in the middle of an iteration
    bus.req = 1'b1;
    bus.data_req = {16'h1234, 8'h56};
    step();
    bus.req = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    acks = 0;
    repeat (20) begin
      if (bus.ack) acks++;
      step();
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_data", {16'd0, bus.data_ack}, 32'd0);
    chk("abort_err", {31'd0, bus.err}, 32'd0);
    run(16'h00FF, 8'h01, lat, dat, e);
    chk("after_abort_lat", lat, 10);
    chk("after_abort_data", {16'd0, dat}, 32'h00FF);
    // req held high: second capture right after FINAL, mid-op data change ignored
    bus.req = 1'b1;
    bus.data_req = {16'h00FF, 8'h01};
    acks = 0;
    a1 = -1;
    a2 = -1;
    d1 = '0;
    d2 = '0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 3) bus.data_req = {16'h0064, 8'h07};
      if (c == 12) bus.req = 1'b0;
      if (bus.ack) begin
        acks++;
        if (acks == 1) begin a1 = c; d1 = bus.data_ack; end
        if (acks == 2) begin a2 = c; d2 = bus.data_ack; end
      end
    end
    chk("b2b_first_lat", a1, 10);
    chk("b2b_first_data", {16'd0, d1}, 32'h00FF);
    chk("b2b_second_lat", a2, 21);
    chk("b2b_second_data", {16'd0, d2}, 32'h020E);
    chk("b2b_ack_count", acks, 2);
    // random sweep against plain integer division
    for (int i = 0; i < 1000; i++) begin
      int dv, dd, qx, rx;
      logic ex;
      if (i % 8 == 7) begin
        dv = $urandom_range(0, 255);
        dd = ($urandom_range(dv, 255) << 8) | $urandom_range(0, 255);
      end else begin
        dv = $urandom_range(1, 255);
        dd = ($urandom_range(0, dv - 1) << 8) | $urandom_range(0, 255);
      end
      ex = dv == 0 || dd / dv > 255;
      qx = ex ? 255 : dd / dv;
      rx = ex ? 0 : dd % dv;
      run(dd[15:0], dv[7:0], lat, dat, e);
      chk("rand_lat", lat, ex ? 2 : 10);
      chk("rand_err", {31'd0, e}, {31'd0, ex});
      chk("rand_data", {16'd0, dat}, (rx << 8) | qx);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
